// File: rtl/pde_pkg.sv
// pde_pkg: shared constants and arithmetic helpers for pipelined_dot_engine
// Contents: default parameter constants, clog2, round_shift (round half up),
// sat_to_w / sat_ovf (signed saturation to w bits and its clamp flag).
package pde_pkg;
   localparam int PDE_LANES  = 32;
   localparam int PDE_DATA_W = 16;
   localparam int PDE_FRAC_W = 8;
   localparam int PDE_ACC_W  = 48;
   // Working width of the rounding/saturation helpers; wide enough for any legal ACC_W.
   localparam int PDE_MAXW   = 128;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

   function automatic logic signed [PDE_MAXW-1:0] round_shift(input logic signed [PDE_MAXW-1:0] x,
                                                              input int frac);
      logic signed [PDE_MAXW-1:0] half;
      half = PDE_MAXW'(1) << (frac - 1);
      return (x + half) >>> frac;
   endfunction

   function automatic logic signed [PDE_MAXW-1:0] sat_to_w(input logic signed [PDE_MAXW-1:0] x,
                                                           input int w);
      logic signed [PDE_MAXW-1:0] hi, lo;
      hi = (PDE_MAXW'(1) << (w - 1)) - PDE_MAXW'(1);
      lo = -hi - PDE_MAXW'(1);
      return x > hi ? hi : x < lo ? lo : x;
   endfunction

   function automatic logic sat_ovf(input logic signed [PDE_MAXW-1:0] x, input int w);
      logic signed [PDE_MAXW-1:0] hi, lo;
      hi = (PDE_MAXW'(1) << (w - 1)) - PDE_MAXW'(1);
      lo = -hi - PDE_MAXW'(1);
      return x > hi || x < lo;
   endfunction
endpackage

// File: rtl/pde_adder_tree.sv
// pde_adder_tree: registered binary reduction of N signed IN_W-bit values, one level per stage
// Ports: clk, rst (async, active-high), en (advance enable; low holds every level),
//        in_valid/in_data (N lanes packed, lane i at [i*IN_W +: IN_W]),
//        out_valid/out_data (IN_W+log2(N) bits, clog2(N) cycles later).
module pde_adder_tree import pde_pkg::*; #(
   parameter int N = 32,
   parameter int IN_W = 32,
   localparam int L = clog2(N),
   localparam int OUT_W = IN_W + L
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              in_valid,
   input  logic [N*IN_W-1:0] in_data,
   output logic              out_valid,
   output logic [OUT_W-1:0]  out_data
);
   for (genvar g = 0; g < L; g++) begin : lvl
      localparam int W = IN_W + g;
      localparam int M = N >> (g + 1);
      logic [2*M*W-1:0]   x;
      logic               vi;
      logic [M*(W+1)-1:0] s;
      logic               v;
      if (g == 0) begin : head
         assign x  = in_data;
         assign vi = in_valid;
      end else begin : body
         assign x  = lvl[g-1].s;
         assign vi = lvl[g-1].v;
      end
      // Each pair is sign-extended by one bit so the sum can never wrap.
      always_ff @(posedge clk or posedge rst)
         if (rst) begin
            s <= '0;
            v <= 1'b0;
         end else if (en) begin
            v <= vi;
            for (int j = 0; j < M; j++)
               s[j*(W+1) +: W+1] <= {x[2*j*W+W-1], x[2*j*W +: W]} +
                                    {x[(2*j+1)*W+W-1], x[(2*j+1)*W +: W]};
         end
   end
   assign out_data  = lvl[L-1].s;
   assign out_valid = lvl[L-1].v;
endmodule

// File: rtl/pipelined_dot_engine.sv
// pipelined_dot_engine: pipelined signed fixed-point multi-beat dot product with bias, round and saturate
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_last, a_flat, b_flat (LANES x DATA_W),
//        bias (used on the last beat only); out_valid/out_ready, result (DATA_W), overflow.
// Build option: define PDE_RELU_EN to clamp negative results to 0 (overflow then flags positive
//        saturation only). Latency is the same either way.
// Stages: S0 input, S1 products, log2(LANES) tree levels, SA accumulate, SR round/saturate, SO output.
module pipelined_dot_engine import pde_pkg::*; #(
   parameter int LANES  = PDE_LANES,
   parameter int DATA_W = PDE_DATA_W,
   parameter int FRAC_W = PDE_FRAC_W,
   parameter int ACC_W  = PDE_ACC_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_last,
   input  logic [LANES*DATA_W-1:0] a_flat,
   input  logic [LANES*DATA_W-1:0] b_flat,
   input  logic [DATA_W-1:0]       bias,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_W-1:0]       result,
   output logic                    overflow
);
   localparam int L  = clog2(LANES);
   localparam int PW = 2 * DATA_W;
   localparam int TW = PW + L;

   // A held output freezes the whole pipe, so every register shares one enable.
   logic en;
   assign en       = !(out_valid && !out_ready);
   assign in_ready = en;

   logic                    s0_v, s0_last;
   logic [DATA_W-1:0]       s0_bias;
   logic [LANES*DATA_W-1:0] s0_a, s0_b;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s0_v    <= 1'b0;
         s0_last <= 1'b0;
         s0_bias <= '0;
         s0_a    <= '0;
         s0_b    <= '0;
      end else if (en) begin
         s0_v    <= in_valid;
         s0_last <= in_last;
         s0_bias <= bias;
         s0_a    <= a_flat;
         s0_b    <= b_flat;
      end

   logic signed [PW-1:0]  ea, eb;
   logic [LANES*PW-1:0]   prod;
   always_comb begin
      ea   = '0;
      eb   = '0;
      prod = '0;
      for (int i = 0; i < LANES; i++) begin
         ea = $signed(s0_a[i*DATA_W +: DATA_W]);
         eb = $signed(s0_b[i*DATA_W +: DATA_W]);
         prod[i*PW +: PW] = ea * eb;
      end
   end

   logic                p_v, p_last;
   logic [DATA_W-1:0]   p_bias;
   logic [LANES*PW-1:0] p;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         p_v    <= 1'b0;
         p_last <= 1'b0;
         p_bias <= '0;
         p      <= '0;
      end else if (en) begin
         p_v    <= s0_v;
         p_last <= s0_last;
         p_bias <= s0_bias;
         p      <= prod;
      end

   logic          tree_v;
   logic [TW-1:0] tree_sum;
   pde_adder_tree #(.N(LANES), .IN_W(PW)) u_tree (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .in_valid (p_v),
      .in_data  (p),
      .out_valid(tree_v),
      .out_data (tree_sum)
   );

   // last/bias tags ride alongside the tree so they line up with its sum.
   logic              lp [L];
   logic [DATA_W-1:0] bp [L];
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int i = 0; i < L; i++) begin
            lp[i] <= 1'b0;
            bp[i] <= '0;
         end
      end else if (en) begin
         lp[0] <= p_last;
         bp[0] <= p_bias;
         for (int i = 1; i < L; i++) begin
            lp[i] <= lp[i-1];
            bp[i] <= bp[i-1];
         end
      end

   logic signed [ACC_W-1:0] acc, fin, tsx, bsx, part;
   logic                    fin_v;
   assign tsx  = ACC_W'($signed(tree_sum));
   assign bsx  = ACC_W'($signed(bp[L-1])) <<< FRAC_W;
   assign part = acc + tsx;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         acc   <= '0;
         fin   <= '0;
         fin_v <= 1'b0;
      end else if (en) begin
         fin_v <= tree_v && lp[L-1];
         if (tree_v) begin
            if (lp[L-1]) begin
               fin <= part + bsx;
               acc <= '0;
            end else
               acc <= part;
         end
      end

   // Rounding and clamping get their own stage to keep the wide add off the output path.
   logic signed [PDE_MAXW-1:0] r;
   logic [DATA_W-1:0]          sat_v;
   logic                       sat_o;
   assign r = round_shift(PDE_MAXW'(fin), FRAC_W);
`ifdef PDE_RELU_EN
   assign sat_v = r[PDE_MAXW-1] ? '0 : DATA_W'(sat_to_w(r, DATA_W));
   assign sat_o = !r[PDE_MAXW-1] && sat_ovf(r, DATA_W);
`else
   assign sat_v = DATA_W'(sat_to_w(r, DATA_W));
   assign sat_o = sat_ovf(r, DATA_W);
`endif

   logic              sr_v, sr_ovf;
   logic [DATA_W-1:0] sr_res;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sr_v   <= 1'b0;
         sr_res <= '0;
         sr_ovf <= 1'b0;
      end else if (en) begin
         sr_v   <= fin_v;
         sr_res <= sat_v;
         sr_ovf <= sat_o;
      end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         out_valid <= 1'b0;
         result    <= '0;
         overflow  <= 1'b0;
      end else if (en) begin
         out_valid <= sr_v;
         if (sr_v) begin
            result   <= sr_res;
            overflow <= sr_ovf;
         end
      end
endmodule

// File: tb/tb_pipelined_dot_engine.sv
// tb_pipelined_dot_engine: directed self-checking bench for pipelined_dot_engine (LANES=32)
module tb_pipelined_dot_engine;
   localparam int LANES = 32, DATA_W = 16, FRAC_W = 8, ACC_W = 48, LAT = 9;

   logic clk = 1'b0, rst = 1'b1;
   logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
   logic in_ready, out_valid, overflow;
   logic [LANES*DATA_W-1:0] a_flat = '0, b_flat = '0;
   logic [DATA_W-1:0] bias = '0, result;
   int n_cmp = 0, n_fail = 0;
   logic [DATA_W-1:0] rq[$];
   logic oq[$];

   always #5 clk = ~clk;

   pipelined_dot_engine #(.LANES(LANES), .DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .a_flat(a_flat), .b_flat(b_flat), .bias(bias), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .overflow(overflow)
   );

   // Inputs only change 1 time unit after a rising edge, so a negedge sample predicts the handshake.
   always @(negedge clk)
      if (!rst && out_valid && out_ready) begin
         rq.push_back(result);
         oq.push_back(overflow);
      end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic beat_raw(input logic [LANES*DATA_W-1:0] av, input logic [LANES*DATA_W-1:0] bv,
                           input logic last, input logic [DATA_W-1:0] bs);
      int k = 0;
      a_flat = av; b_flat = bv; in_last = last; bias = bs; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && k < 100) begin @(negedge clk); k++; end
      if (!in_ready) begin
         n_cmp++; n_fail++;
         $display("FAIL beat_accept: in_ready=%b required 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic beat(input logic [DATA_W-1:0] av, input logic [DATA_W-1:0] bv,
                       input logic last, input logic [DATA_W-1:0] bs);
      logic [LANES*DATA_W-1:0] va, vb;
      for (int i = 0; i < LANES; i++) begin
         va[i*DATA_W +: DATA_W] = av;
         vb[i*DATA_W +: DATA_W] = bv;
      end
      beat_raw(va, vb, last, bs);
   endtask

   task automatic wait_q(input int n, output bit ok);
      int k = 0;
      while (rq.size() < n && k < 200) begin @(negedge clk); k++; end
      ok = rq.size() >= n;
   endtask

   function automatic logic [DATA_W-1:0] stream_b(input int i);
      logic signed [DATA_W-1:0] b;
      b = DATA_W'(8 * (i + 1));
      return (i % 2 == 1) ? -b : b;
   endfunction

   function automatic logic [DATA_W-1:0] stream_exp(input int i);
      logic signed [DATA_W-1:0] b;
      b = stream_b(i);
`ifdef PDE_RELU_EN
      if (b < 0) return '0;
`endif
      return DATA_W'(32 * int'(b));
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
      n_cmp++; if (result !== 16'h0000) begin n_fail++; $display("FAIL reset_result: got %h required 0000", result); end
      n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b required 0", overflow); end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_out_valid: got %b required 0", out_valid); end
   endtask

   task automatic test_basic();
      int lat = 0;
      bit ok;
      rq.delete(); oq.delete();
      @(posedge clk); #1;
      beat(16'h0100, 16'h0100, 1'b1, 16'h0000);
      @(negedge clk);
      while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
      n_cmp++; if (lat != LAT) begin n_fail++; $display("FAIL basic_latency: got %0d required %0d", lat, LAT); end
      wait_q(1, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL basic_arrive: got %0d results required 1", rq.size()); end
      else begin
         n_cmp++; if (rq[0] !== 16'h2000) begin n_fail++; $display("FAIL basic_result: got %h required 2000", rq[0]); end
         n_cmp++; if (oq[0] !== 1'b0) begin n_fail++; $display("FAIL basic_overflow: got %b required 0", oq[0]); end
      end
   endtask

   task automatic test_multibeat();
      bit ok;
      rq.delete(); oq.delete();
      @(posedge clk); #1;
      beat(16'h0100, 16'h0080, 1'b0, 16'h7777);
      beat(16'h0100, 16'h0080, 1'b0, 16'h7777);
      repeat (3) @(posedge clk);
      #1;
      beat(16'h0100, 16'h0080, 1'b1, 16'h0100);
      beat(16'h0100, 16'h0100, 1'b1, 16'h0000);
      wait_q(2, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL multi_arrive: got %0d results required 2", rq.size()); end
      else begin
         n_cmp++; if (rq[0] !== 16'h3100) begin n_fail++; $display("FAIL multi_result: got %h required 3100", rq[0]); end
         n_cmp++; if (oq[0] !== 1'b0) begin n_fail++; $display("FAIL multi_overflow: got %b required 0", oq[0]); end
         n_cmp++; if (rq[1] !== 16'h2000) begin n_fail++; $display("FAIL multi_acc_cleared: got %h required 2000", rq[1]); end
      end
   endtask

   task automatic test_saturation();
      bit ok;
      logic [DATA_W-1:0] neg_r;
      logic neg_o;
`ifdef PDE_RELU_EN
      neg_r = 16'h0000; neg_o = 1'b0;
`else
      neg_r = 16'h8000; neg_o = 1'b1;
`endif
      rq.delete(); oq.delete();
      @(posedge clk); #1;
      beat(16'h7FFF, 16'h7FFF, 1'b1, 16'h0000);
      beat(16'h8000, 16'h7FFF, 1'b1, 16'h0000);
      wait_q(2, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL sat_arrive: got %0d results required 2", rq.size()); end
      else begin
         n_cmp++; if (rq[0] !== 16'h7FFF) begin n_fail++; $display("FAIL sat_pos_result: got %h required 7fff", rq[0]); end
         n_cmp++; if (oq[0] !== 1'b1) begin n_fail++; $display("FAIL sat_pos_overflow: got %b required 1", oq[0]); end
         n_cmp++; if (rq[1] !== neg_r) begin n_fail++; $display("FAIL sat_neg_result: got %h required %h", rq[1], neg_r); end
         n_cmp++; if (oq[1] !== neg_o) begin n_fail++; $display("FAIL sat_neg_overflow: got %b required %b", oq[1], neg_o); end
      end
   endtask

   task automatic test_rounding();
      bit ok;
      logic [DATA_W-1:0] neg_r;
      logic [LANES*DATA_W-1:0] va, vb;
`ifdef PDE_RELU_EN
      neg_r = 16'h0000;
`else
      neg_r = 16'hE000;
`endif
      rq.delete(); oq.delete();
      @(posedge clk); #1;
      va = '0; vb = '0;
      va[DATA_W-1:0] = 16'h0001; vb[DATA_W-1:0] = 16'h0080;
      beat_raw(va, vb, 1'b1, 16'h0000);
      va[DATA_W-1:0] = 16'hFFFF;
      beat_raw(va, vb, 1'b1, 16'h0000);
      beat(16'hFF00, 16'h0100, 1'b1, 16'h0000);
      wait_q(3, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL round_arrive: got %0d results required 3", rq.size()); end
      else begin
         n_cmp++; if (rq[0] !== 16'h0001) begin n_fail++; $display("FAIL round_pos_half: got %h required 0001", rq[0]); end
         n_cmp++; if (rq[1] !== 16'h0000) begin n_fail++; $display("FAIL round_neg_half: got %h required 0000", rq[1]); end
         n_cmp++; if (rq[2] !== neg_r) begin n_fail++; $display("FAIL round_negative: got %h required %h", rq[2], neg_r); end
         n_cmp++; if (oq[2] !== 1'b0) begin n_fail++; $display("FAIL round_neg_overflow: got %b required 0", oq[2]); end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      rq.delete(); oq.delete();
      out_ready = 1'b1;
      @(posedge clk); #1;
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               beat(16'h0100, stream_b(i), 1'b1, 16'h0000);
               if (i == 4) begin
                  repeat (6) @(posedge clk);
                  #1;
               end
            end
         end
         begin
            int k = 0;
            logic [DATA_W-1:0] held;
            logic held_o;
            @(negedge clk);
            while (!out_valid && k < 50) begin @(negedge clk); k++; end
            @(posedge clk); #1;
            out_ready = 1'b0;
            @(negedge clk);
            held = result; held_o = overflow;
            n_cmp++; if (held !== stream_exp(1)) begin n_fail++; $display("FAIL stall_held_value: got %h required %h", held, stream_exp(1)); end
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b required 0", in_ready); end
            for (int c = 1; c < 5; c++) begin
               @(negedge clk);
               n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid_c%0d: got %b required 1", c, out_valid); end
               n_cmp++; if (result !== held) begin n_fail++; $display("FAIL stall_result_c%0d: got %h required %h", c, result, held); end
               n_cmp++; if (overflow !== held_o) begin n_fail++; $display("FAIL stall_ovf_c%0d: got %b required %b", c, overflow, held_o); end
               n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready_c%0d: got %b required 0", c, in_ready); end
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      wait_q(10, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL stream_arrive: got %0d results required 10", rq.size()); end
      else
         for (int i = 0; i < 10; i++) begin
            n_cmp++; if (rq[i] !== stream_exp(i)) begin n_fail++; $display("FAIL stream_result_%0d: got %h required %h", i, rq[i], stream_exp(i)); end
         end
      repeat (20) @(negedge clk);
      n_cmp++; if (rq.size() != 10) begin n_fail++; $display("FAIL stream_count: got %0d required 10", rq.size()); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      rq.delete(); oq.delete();
      @(posedge clk); #1;
      beat(16'h0100, 16'h0100, 1'b0, 16'h0000);
      beat(16'h0100, 16'h0100, 1'b0, 16'h0000);
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      beat(16'h0100, 16'h0080, 1'b1, 16'h0000);
      wait_q(1, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL rstmid_arrive: got %0d results required 1", rq.size()); end
      else begin
         n_cmp++; if (rq[0] !== 16'h1000) begin n_fail++; $display("FAIL rstmid_result: got %h required 1000", rq[0]); end
      end
      repeat (20) @(negedge clk);
      n_cmp++; if (rq.size() != 1) begin n_fail++; $display("FAIL rstmid_count: got %0d required 1", rq.size()); end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_basic();
      test_multibeat();
      test_saturation();
      test_rounding();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
